// File: rtl/gpregs_dumper.sv
// ---------------------------------------------------------------------------
// gpregs_dumper
//
// Sequential read-out engine for the general-purpose register file. A start
// pulse in IDLE latches an inclusive index range [first_reg, last_reg]. The
// engine then walks that range through one GPREGS read port. Each register
// value is captured and presented as an (index, data) beat on a valid/ready
// stream. When the last beat has been accepted, a one-cycle done pulse is
// issued. A reversed range (first_reg > last_reg) is rejected immediately:
// done and range_err pulse together and no beats are sent.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; aborts any dump in progress
//   start       begin a dump (only looked at while idle)
//   first_reg   first register index of the range, sampled with start
//   last_reg    last register index of the range (inclusive), sampled with start
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse at the end of a dump or a rejected start
//   range_err   one-cycle pulse with done when the range was reversed
//   read_reg    index presented to the GPREGS read port
//   read_data   combinational GPREGS read data for read_reg
//   dout_valid  stream beat valid
//   dout_ready  stream sink ready
//   dout_reg    register index carried by the current beat
//   dout_data   register value carried by the current beat
//
// Per-beat timing with the sink always ready:
//   READ -> SEND -> READ -> SEND ... -> FIN -> IDLE,
// which gives one beat every two cycles.
// ---------------------------------------------------------------------------
module gpregs_dumper #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [REG_ADDR_WIDTH-1:0] first_reg,
    input  logic [REG_ADDR_WIDTH-1:0] last_reg,
    output logic                      busy,
    output logic                      done,
    output logic                      range_err,
    output logic [REG_ADDR_WIDTH-1:0] read_reg,
    input  logic [REG_DATA_WIDTH-1:0] read_data,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [REG_ADDR_WIDTH-1:0] dout_reg,
    output logic [REG_DATA_WIDTH-1:0] dout_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                    state;
    logic [REG_ADDR_WIDTH-1:0] idx;
    logic [REG_ADDR_WIDTH-1:0] last_idx;
    logic                      err_flag;

    // The read port always follows the walk index, so read_data is already
    // settled for the current index when the READ edge captures it.
    assign read_reg  = idx;

    // Status outputs decode straight from the state register.
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign range_err = (state == FIN) && err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            last_idx   <= '0;
            err_flag   <= 1'b0;
            dout_valid <= 1'b0;
            dout_reg   <= '0;
            dout_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (first_reg <= last_reg) begin
                            idx      <= first_reg;
                            last_idx <= last_reg;
                            state    <= READ;
                        end else begin
                            // Reversed range: report and finish without
                            // touching the walk registers.
                            err_flag <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end

                READ: begin
                    dout_data  <= read_data;
                    dout_reg   <= idx;
                    dout_valid <= 1'b1;
                    state      <= SEND;
                end

                SEND: begin
                    // Beat stays frozen until the sink takes it.
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        // Compare before incrementing so a range ending at
                        // the top index never wraps back to zero.
                        if (idx == last_idx) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + REG_ADDR_WIDTH'(1);
                            state <= READ;
                        end
                    end
                end

                FIN: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
